// File: rtl/uart_param.sv
// Parameterised UART: baud-tick generator, TX/RX framing FSMs with optional parity,
// and first-word fall-through TX and RX FIFOs with sticky receive status.
module uart_param #(
    parameter int unsigned CLK_HZ     = 100000000,
    parameter int unsigned BAUD       = 9600,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY     = 0,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DATA_BITS-1:0] tx_data_in,
    input  logic                 write_tx_data,
    output logic                 tx_buffer_full,
    output logic                 tx_busy,
    output logic                 rs232_tx,
    input  logic                 rs232_rx,
    output logic [DATA_BITS-1:0] rx_data_out,
    input  logic                 read_rx_data_ack,
    output logic                 rx_data_present,
    output logic                 rx_buffer_full,
    output logic [2:0]           rx_status,
    input  logic                 clear_status
);
    localparam int unsigned DIV_RAW = (CLK_HZ + 8 * BAUD) / (16 * BAUD);
    localparam int unsigned DIV     = (DIV_RAW == 0) ? 1 : DIV_RAW;
    localparam int unsigned CW      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned AW      = $clog2(FIFO_DEPTH);
    localparam int unsigned BW      = $clog2(DATA_BITS);
    localparam logic [CW-1:0]  DIV_LAST  = CW'(DIV - 1);
    localparam logic [4:0]     STOP_LAST = 5'(STOP_BITS * 16 - 1);
    localparam logic [BW-1:0]  BIT_LAST  = BW'(DATA_BITS - 1);
    localparam logic [AW:0]    FIFO_FULL = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {TxIdle, TxStart, TxData, TxParity, TxStop} tx_state_e;
    typedef enum logic [2:0] {RxIdle, RxStart, RxData, RxParity, RxStop} rx_state_e;

    // Baud tick at 16x the bit rate
    logic [CW-1:0] r_baud_cnt;
    logic          w_tick;

    assign w_tick = (r_baud_cnt == DIV_LAST);

    always_ff @(posedge clk) begin
        if (reset || w_tick) r_baud_cnt <= '0;
        else                 r_baud_cnt <= r_baud_cnt + 1'b1;
    end

    // TX FIFO
    logic [DATA_BITS-1:0] r_tx_mem [FIFO_DEPTH];
    logic [AW-1:0]        r_tx_wptr, r_tx_rptr;
    logic [AW:0]          r_tx_cnt;
    logic                 w_tx_empty, w_tx_full, w_tx_push, w_tx_pop;
    logic [DATA_BITS-1:0] w_tx_head;
    logic                 w_tx_head_par;

    tx_state_e            r_tx_state;
    logic [4:0]           r_tx_tick;
    logic [BW-1:0]        r_tx_bit;
    logic [DATA_BITS-1:0] r_tx_shift;
    logic                 r_tx_par;
    logic                 r_tx;

    assign w_tx_empty    = (r_tx_cnt == '0);
    assign w_tx_full     = (r_tx_cnt == FIFO_FULL);
    assign w_tx_push     = write_tx_data && !w_tx_full;
    assign w_tx_head     = r_tx_mem[r_tx_rptr];
    assign w_tx_head_par = (PARITY == 1) ? ~^w_tx_head : ^w_tx_head;
    // Pop from IDLE, or straight out of the last stop tick for back-to-back frames
    assign w_tx_pop = w_tick && !w_tx_empty &&
                      ((r_tx_state == TxIdle) ||
                       (r_tx_state == TxStop && r_tx_tick == STOP_LAST));

    always_ff @(posedge clk) begin
        if (w_tx_push) r_tx_mem[r_tx_wptr] <= tx_data_in;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_tx_wptr <= '0;
            r_tx_rptr <= '0;
            r_tx_cnt  <= '0;
        end else begin
            if (w_tx_push) r_tx_wptr <= r_tx_wptr + 1'b1;
            if (w_tx_pop)  r_tx_rptr <= r_tx_rptr + 1'b1;
            if (w_tx_push && !w_tx_pop)      r_tx_cnt <= r_tx_cnt + 1'b1;
            else if (!w_tx_push && w_tx_pop) r_tx_cnt <= r_tx_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_tx_state <= TxIdle;
            r_tx_tick  <= '0;
            r_tx_bit   <= '0;
            r_tx_shift <= '0;
            r_tx_par   <= 1'b0;
            r_tx       <= 1'b1;
        end else begin
            case (r_tx_state)
                TxIdle: begin
                    if (w_tx_pop) begin
                        r_tx_state <= TxStart;
                        r_tx_shift <= w_tx_head;
                        r_tx_par   <= w_tx_head_par;
                        r_tx_tick  <= '0;
                        r_tx       <= 1'b0;
                    end
                end
                TxStart: begin
                    if (w_tick) begin
                        if (r_tx_tick == 5'd15) begin
                            r_tx_state <= TxData;
                            r_tx_tick  <= '0;
                            r_tx_bit   <= '0;
                            r_tx       <= r_tx_shift[0];
                            r_tx_shift <= {1'b0, r_tx_shift[DATA_BITS-1:1]};
                        end else begin
                            r_tx_tick <= r_tx_tick + 1'b1;
                        end
                    end
                end
                TxData: begin
                    if (w_tick) begin
                        if (r_tx_tick == 5'd15) begin
                            r_tx_tick <= '0;
                            if (r_tx_bit == BIT_LAST) begin
                                r_tx_state <= (PARITY != 0) ? TxParity : TxStop;
                                r_tx       <= (PARITY != 0) ? r_tx_par : 1'b1;
                            end else begin
                                r_tx_bit   <= r_tx_bit + 1'b1;
                                r_tx       <= r_tx_shift[0];
                                r_tx_shift <= {1'b0, r_tx_shift[DATA_BITS-1:1]};
                            end
                        end else begin
                            r_tx_tick <= r_tx_tick + 1'b1;
                        end
                    end
                end
                TxParity: begin
                    if (w_tick) begin
                        if (r_tx_tick == 5'd15) begin
                            r_tx_state <= TxStop;
                            r_tx_tick  <= '0;
                            r_tx       <= 1'b1;
                        end else begin
                            r_tx_tick <= r_tx_tick + 1'b1;
                        end
                    end
                end
                TxStop: begin
                    if (w_tick) begin
                        if (r_tx_tick == STOP_LAST) begin
                            r_tx_tick <= '0;
                            if (w_tx_pop) begin
                                r_tx_state <= TxStart;
                                r_tx_shift <= w_tx_head;
                                r_tx_par   <= w_tx_head_par;
                                r_tx       <= 1'b0;
                            end else begin
                                r_tx_state <= TxIdle;
                            end
                        end else begin
                            r_tx_tick <= r_tx_tick + 1'b1;
                        end
                    end
                end
                default: begin
                    r_tx_state <= TxIdle;
                    r_tx       <= 1'b1;
                end
            endcase
        end
    end

    assign rs232_tx       = r_tx;
    assign tx_busy        = !w_tx_empty || (r_tx_state != TxIdle);
    assign tx_buffer_full = w_tx_full;

    // RX synchronizer and framing
    logic                 r_rx_meta, r_rx_sync;
    rx_state_e            r_rx_state;
    logic [3:0]           r_rx_tick;
    logic [BW-1:0]        r_rx_bit;
    logic [DATA_BITS-1:0] r_rx_shift;
    logic [2:0]           r_status;
    logic                 w_rx_sample, w_rx_par_exp;
    logic                 w_rx_frame_ok, w_set_ovr, w_set_par, w_set_frm;

    logic [DATA_BITS-1:0] r_rx_mem [FIFO_DEPTH];
    logic [AW-1:0]        r_rx_wptr, r_rx_rptr;
    logic [AW:0]          r_rx_cnt;
    logic                 w_rx_empty, w_rx_full, w_rx_push, w_rx_pop;

    assign w_rx_sample   = w_tick && (r_rx_tick == 4'd15);
    assign w_rx_par_exp  = (PARITY == 1) ? ~^r_rx_shift : ^r_rx_shift;
    assign w_rx_frame_ok = (r_rx_state == RxStop) && w_rx_sample && r_rx_sync;
    assign w_set_frm     = (r_rx_state == RxStop) && w_rx_sample && !r_rx_sync;
    assign w_set_par     = (r_rx_state == RxParity) && w_rx_sample &&
                           (r_rx_sync != w_rx_par_exp);
    assign w_set_ovr     = w_rx_frame_ok && w_rx_full;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
        end else begin
            r_rx_meta <= rs232_rx;
            r_rx_sync <= r_rx_meta;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rx_state <= RxIdle;
            r_rx_tick  <= '0;
            r_rx_bit   <= '0;
            r_rx_shift <= '0;
        end else if (w_tick) begin
            case (r_rx_state)
                RxIdle: begin
                    if (!r_rx_sync) begin
                        r_rx_state <= RxStart;
                        r_rx_tick  <= '0;
                    end
                end
                RxStart: begin
                    // Mid-start re-check rejects short glitches
                    if (r_rx_tick == 4'd7) begin
                        r_rx_state <= r_rx_sync ? RxIdle : RxData;
                        r_rx_tick  <= '0;
                        r_rx_bit   <= '0;
                    end else begin
                        r_rx_tick <= r_rx_tick + 1'b1;
                    end
                end
                RxData: begin
                    r_rx_tick <= r_rx_tick + 1'b1;
                    if (r_rx_tick == 4'd15) begin
                        r_rx_shift <= {r_rx_sync, r_rx_shift[DATA_BITS-1:1]};
                        if (r_rx_bit == BIT_LAST) r_rx_state <= (PARITY != 0) ? RxParity : RxStop;
                        else                      r_rx_bit   <= r_rx_bit + 1'b1;
                    end
                end
                RxParity: begin
                    r_rx_tick <= r_rx_tick + 1'b1;
                    if (r_rx_tick == 4'd15) r_rx_state <= RxStop;
                end
                RxStop: begin
                    r_rx_tick <= r_rx_tick + 1'b1;
                    if (r_rx_tick == 4'd15) r_rx_state <= RxIdle;
                end
                default: r_rx_state <= RxIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) r_status <= 3'b000;
        else       r_status <= (clear_status ? 3'b000 : r_status) |
                               {w_set_ovr, w_set_par, w_set_frm};
    end

    // RX FIFO
    assign w_rx_empty = (r_rx_cnt == '0);
    assign w_rx_full  = (r_rx_cnt == FIFO_FULL);
    assign w_rx_push  = w_rx_frame_ok && !w_rx_full;
    assign w_rx_pop   = read_rx_data_ack && !w_rx_empty;

    always_ff @(posedge clk) begin
        if (w_rx_push) r_rx_mem[r_rx_wptr] <= r_rx_shift;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rx_wptr <= '0;
            r_rx_rptr <= '0;
            r_rx_cnt  <= '0;
        end else begin
            if (w_rx_push) r_rx_wptr <= r_rx_wptr + 1'b1;
            if (w_rx_pop)  r_rx_rptr <= r_rx_rptr + 1'b1;
            if (w_rx_push && !w_rx_pop)      r_rx_cnt <= r_rx_cnt + 1'b1;
            else if (!w_rx_push && w_rx_pop) r_rx_cnt <= r_rx_cnt - 1'b1;
        end
    end

    assign rx_data_out     = r_rx_mem[r_rx_rptr];
    assign rx_data_present = !w_rx_empty;
    assign rx_buffer_full  = w_rx_full;
    assign rx_status       = r_status;

endmodule

// File: tb/tb_uart_param.sv
// Directed + randomized bench for uart_param (16x oversampling, 160 clk per bit, 8E1, depth 4).
module tb_uart_param;
    localparam int BIT_CLK = 160;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] tx_data_in = 8'h00;
    logic       write_tx_data = 1'b0;
    logic       tx_buffer_full, tx_busy, rs232_tx;
    logic [7:0] rx_data_out;
    logic       read_rx_data_ack = 1'b0;
    logic       rx_data_present, rx_buffer_full;
    logic [2:0] rx_status;
    logic       clear_status = 1'b0;
    logic       loopback = 1'b0;
    logic       rx_drv = 1'b1;
    logic       rx_line;

    int         n_checks = 0;
    int         n_errors = 0;
    int         cyc = 0;
    logic [7:0] exp_q[$];

    assign rx_line = loopback ? rs232_tx : rx_drv;

    uart_param #(
        .CLK_HZ    (1600000),
        .BAUD      (10000),
        .DATA_BITS (8),
        .PARITY    (2),
        .STOP_BITS (1),
        .FIFO_DEPTH(4)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .tx_data_in      (tx_data_in),
        .write_tx_data   (write_tx_data),
        .tx_buffer_full  (tx_buffer_full),
        .tx_busy         (tx_busy),
        .rs232_tx        (rs232_tx),
        .rs232_rx        (rx_line),
        .rx_data_out     (rx_data_out),
        .read_rx_data_ack(read_rx_data_ack),
        .rx_data_present (rx_data_present),
        .rx_buffer_full  (rx_buffer_full),
        .rx_status       (rx_status),
        .clear_status    (clear_status)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #900us;
        $display("FAIL watchdog: observed no finish expected finish before 900us");
        $fatal(1);
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Even parity: bit that makes the total count of ones even
    function automatic logic even_par(input logic [7:0] d);
        return ($countones(d) % 2) == 1;
    endfunction

    task automatic push_tx(input logic [7:0] d);
        tx_data_in    = d;
        write_tx_data = 1'b1;
        step(1);
        write_tx_data = 1'b0;
    endtask

    task automatic ack_rx();
        read_rx_data_ack = 1'b1;
        step(1);
        read_rx_data_ack = 1'b0;
    endtask

    task automatic pulse_clear();
        clear_status = 1'b1;
        step(1);
        clear_status = 1'b0;
    endtask

    task automatic wait_tx_low(output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (rs232_tx == 1'b0) begin
                ok = 1'b1;
                break;
            end
            step(1);
        end
    endtask

    task automatic wait_present(input int bound, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            if (rx_data_present) begin
                ok = 1'b1;
                break;
            end
            step(1);
        end
    endtask

    // Short low stop bit keeps the line from looking like a fresh start afterwards
    task automatic send_frame(input logic [7:0] d, input logic par_bit, input logic stop_val);
        rx_drv = 1'b0;
        step(BIT_CLK);
        for (int i = 0; i < 8; i++) begin
            rx_drv = d[i];
            step(BIT_CLK);
        end
        rx_drv = par_bit;
        step(BIT_CLK);
        rx_drv = stop_val;
        step(stop_val ? BIT_CLK : 120);
        rx_drv = 1'b1;
        step(BIT_CLK);
    endtask

    initial begin
        logic [7:0] d;
        logic       ok;
        int         n;
        int         c_start, c_end;

        step(3);
        check("rst_tx_line", 32'(rs232_tx), 32'd1);
        check("rst_tx_busy", 32'(tx_busy), 32'd0);
        check("rst_tx_full", 32'(tx_buffer_full), 32'd0);
        check("rst_rx_present", 32'(rx_data_present), 32'd0);
        check("rst_rx_full", 32'(rx_buffer_full), 32'd0);
        check("rst_status", 32'(rx_status), 32'd0);
        reset = 1'b0;
        step(2);
        check("post_rst_tx_line", 32'(rs232_tx), 32'd1);

        // Loopback of 0xA5 with bit-level line checks
        loopback = 1'b1;
        d = 8'hA5;
        push_tx(d);
        check("busy_after_write", 32'(tx_busy), 32'd1);
        wait_tx_low(ok);
        check("a5_start_seen", 32'(ok), 32'd1);
        n = 0;
        while (rs232_tx == 1'b0 && n < 400) begin
            step(1);
            n++;
        end
        check("a5_start_len", 32'(n), 32'(BIT_CLK));
        step(BIT_CLK / 2);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("a5_bit%0d", i), 32'(rs232_tx), 32'(d[i]));
            step(BIT_CLK);
        end
        check("a5_parity", 32'(rs232_tx), 32'(even_par(d)));
        step(BIT_CLK);
        check("a5_stop", 32'(rs232_tx), 32'd1);
        wait_present(300, ok);
        check("a5_rx_seen", 32'(ok), 32'd1);
        check("a5_rx_data", 32'(rx_data_out), 32'(d));
        check("a5_rx_status", 32'(rx_status), 32'd0);
        ack_rx();
        check("a5_rx_popped", 32'(rx_data_present), 32'd0);
        step(2 * BIT_CLK);
        check("a5_tx_idle", 32'(tx_busy), 32'd0);

        // Back-to-back random frames, TX FIFO fill and write-when-full
        d = 8'($urandom);
        exp_q.push_back(d);
        push_tx(d);
        wait_tx_low(ok);
        check("b2b_start_seen", 32'(ok), 32'd1);
        c_start = cyc;
        for (int i = 0; i < 4; i++) begin
            d = 8'($urandom);
            exp_q.push_back(d);
            push_tx(d);
        end
        check("tx_full_after_4", 32'(tx_buffer_full), 32'd1);
        push_tx(8'($urandom));
        check("tx_full_after_extra", 32'(tx_buffer_full), 32'd1);
        c_end = c_start;
        fork
            begin
                while (tx_busy && (cyc - c_start) < 10000) step(1);
                c_end = cyc;
            end
            begin
                logic okb;
                for (int k = 0; k < 5; k++) begin
                    wait_present(2500, okb);
                    check($sformatf("b2b_rx_seen%0d", k), 32'(okb), 32'd1);
                    check($sformatf("b2b_rx_data%0d", k), 32'(rx_data_out),
                          32'(exp_q.pop_front()));
                    ack_rx();
                end
            end
        join
        check("b2b_duration", 32'(c_end - c_start), 32'(5 * 11 * BIT_CLK));
        check("b2b_status", 32'(rx_status), 32'd0);
        step(BIT_CLK);
        check("b2b_no_extra_rx", 32'(rx_data_present), 32'd0);

        // Random externally driven frames with correct parity
        loopback = 1'b0;
        for (int k = 0; k < 4; k++) begin
            d = 8'($urandom);
            send_frame(d, even_par(d), 1'b1);
            wait_present(20, ok);
            check($sformatf("rnd_seen%0d", k), 32'(ok), 32'd1);
            check($sformatf("rnd_data%0d", k), 32'(rx_data_out), 32'(d));
            check($sformatf("rnd_status%0d", k), 32'(rx_status), 32'd0);
            ack_rx();
        end

        // Parity error: frame still delivered, parity_err sticky until cleared
        send_frame(8'h03, 1'b1, 1'b1);
        check("par_present", 32'(rx_data_present), 32'd1);
        check("par_data", 32'(rx_data_out), 32'h03);
        check("par_status", 32'(rx_status), 32'b010);
        pulse_clear();
        check("par_cleared", 32'(rx_status), 32'b000);
        ack_rx();

        // Framing error: nothing pushed
        d = 8'h5A;
        send_frame(d, even_par(d), 1'b0);
        check("frm_no_push", 32'(rx_data_present), 32'd0);
        check("frm_status", 32'(rx_status), 32'b001);
        pulse_clear();
        check("frm_cleared", 32'(rx_status), 32'b000);

        // 3-tick glitch rejected
        rx_drv = 1'b0;
        step(30);
        rx_drv = 1'b1;
        step(4 * BIT_CLK);
        check("glitch_no_push", 32'(rx_data_present), 32'd0);
        check("glitch_status", 32'(rx_status), 32'd0);

        // Overrun: five frames into a four-entry FIFO
        exp_q.delete();
        for (int k = 0; k < 5; k++) begin
            d = 8'($urandom);
            exp_q.push_back(d);
            send_frame(d, even_par(d), 1'b1);
        end
        check("ovr_rx_full", 32'(rx_buffer_full), 32'd1);
        check("ovr_status", 32'(rx_status), 32'b100);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("ovr_data%0d", k), 32'(rx_data_out), 32'(exp_q[k]));
            ack_rx();
        end
        check("ovr_drained", 32'(rx_data_present), 32'd0);
        pulse_clear();

        // Reset during TX data bit 3 aborts the frame and flushes the FIFO
        push_tx(8'h00);
        push_tx(8'h55);
        wait_tx_low(ok);
        check("rst_tx_start_seen", 32'(ok), 32'd1);
        step(BIT_CLK + 3 * BIT_CLK + BIT_CLK / 2);
        check("rst_tx_bit3_low", 32'(rs232_tx), 32'd0);
        reset = 1'b1;
        step(1);
        check("rst_mid_tx_line", 32'(rs232_tx), 32'd1);
        check("rst_mid_tx_busy", 32'(tx_busy), 32'd0);
        reset = 1'b0;
        n = 0;
        for (int i = 0; i < 400; i++) begin
            if (rs232_tx == 1'b0) n++;
            step(1);
        end
        check("rst_tx_stays_idle", 32'(n), 32'd0);
        check("rst_tx_busy_after", 32'(tx_busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/uart_param.md
UART_PARAM -- requirements
Module: uart_param

Interface
REQ-001 SHALL have parameter CLK_HZ, default 100000000: system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 9600: serial bit rate.
REQ-003 SHALL have parameter DATA_BITS, default 8: data bits per frame, legal 5..8.
REQ-004 SHALL have parameter PARITY, default 0: 0 none, 1 odd, 2 even.
REQ-005 SHALL have parameter STOP_BITS, default 1: stop bits transmitted, legal 1 or 2.
REQ-006 SHALL have parameter FIFO_DEPTH, default 16: entries per TX and RX FIFO, power of two, at least 2.
REQ-007 SHALL have port clk, input, 1: single clock; all logic on the rising edge.
REQ-008 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-009 SHALL have port tx_data_in, input, DATA_BITS: byte to transmit.
REQ-010 SHALL have port write_tx_data, input, 1: push tx_data_in into the TX FIFO.
REQ-011 SHALL have port tx_buffer_full, output, 1: TX FIFO holds FIFO_DEPTH entries.
REQ-012 SHALL have port tx_busy, output, 1: TX FIFO non-empty or a frame in progress.
REQ-013 SHALL have port rs232_tx, output, 1: serial output, idle high.
REQ-014 SHALL have port rs232_rx, input, 1: asynchronous serial input.
REQ-015 SHALL have port rx_data_out, output, DATA_BITS: RX FIFO head (first-word fall-through).
REQ-016 SHALL have port read_rx_data_ack, input, 1: pop the RX FIFO head.
REQ-017 SHALL have port rx_data_present, output, 1: RX FIFO non-empty.
REQ-018 SHALL have port rx_buffer_full, output, 1: RX FIFO full.
REQ-019 SHALL have port rx_status, output, 3: sticky {overrun, parity_err, framing_err}.
REQ-020 SHALL have port clear_status, input, 1: clear rx_status.

Function
REQ-021 SHALL compute DIV = round(CLK_HZ/(16*BAUD)) at elaboration; the baud counter SHALL run 0..DIV-1 and assert a one-clk tick when the count equals DIV-1.
REQ-022 Bit period SHALL be 16 ticks; data SHALL be sent and received LSB first.
REQ-023 TX FSM SHALL use states IDLE, START, DATA, PARITY, STOP; PARITY is skipped when PARITY=0.
REQ-024 In IDLE with the TX FIFO non-empty, the head SHALL be popped on the next tick and START entered; rs232_tx goes low that cycle.
REQ-025 TX SHALL send STOP_BITS×16 ticks high, then go to IDLE; back-to-back frames SHALL have no extra idle time.
REQ-026 rs232_rx SHALL pass through a 2-flop synchronizer before any use.
REQ-027 RX FSM states SHALL be IDLE, START, DATA, PARITY, STOP.
REQ-028 RX in IDLE: a low sample SHALL start START.
REQ-029 RX in START: the line SHALL be re-sampled at tick 8; if high, return to IDLE (glitch reject), no status change.
REQ-030 RX data and parity bits SHALL be sampled 16 ticks after the previous sample point (mid-bit).
REQ-031 RX SHALL check exactly one stop bit, regardless of STOP_BITS.
REQ-032 A low stop bit SHALL set framing_err and discard the frame.
REQ-033 A parity mismatch SHALL set parity_err; the frame is still pushed.
REQ-034 RX SHALL return to IDLE at the stop-bit sample point.
REQ-035 A completed frame arriving with the RX FIFO full SHALL be dropped and set overrun; FIFO contents are unchanged.
REQ-036 A write to a full FIFO, or a read of an empty FIFO, SHALL be ignored, including same-cycle pop/write.
REQ-037 Simultaneous push and pop on a non-full, non-empty FIFO SHALL both occur, with occupancy unchanged.
REQ-038 When the FIFO is empty, rx_data_out is don't-care.
REQ-039 rx_data_present SHALL assert the clk after the push.
REQ-040 clear_status SHALL clear rx_status next clk; a same-cycle set event SHALL win over the clear.

Reset
REQ-041 reset SHALL, at the next clk edge, empty both FIFOs, zero the baud counter, put both FSMs in IDLE and clear rx_status.
REQ-042 During and after reset: rs232_tx=1, tx_busy=0, tx_buffer_full=0, rx_data_present=0, rx_buffer_full=0, rx_status=3'b000.
REQ-043 Reset mid-frame SHALL abort the frame immediately with no partial push.

Verification
REQ-044 Loopback: CLK_HZ=1600000, BAUD=10000 (DIV=10); write 0xA5 -> rs232_tx start bit lasts 160 clk, data 1,0,1,0,0,1,0,1, stop high; RX pushes 0xA5; rx_status=000.
REQ-045 Parity: PARITY=2; receive 0x03 with parity bit 1 -> rx_data_out=0x03, rx_status=3'b010; clear_status -> 000.
REQ-046 Framing: stop bit driven low -> nothing pushed, rx_status=3'b001.
REQ-047 Overrun: FIFO_DEPTH=4; receive 5 frames with no ack -> first 4 bytes retained in order, rx_buffer_full=1, rx_status[2]=1.
REQ-048 Glitch/reset: a 3-tick low pulse on rs232_rx -> no push. Reset asserted during TX data bit 3 -> rs232_tx=1 the next clk and tx_busy=0.
